// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared types, constants and fixed-point helpers for the sine/cosine Horner block
package sine_pkg;

  typedef enum logic [2:0] {IDLE, SQR, HORN, FIN, DONE} state_t;

  // Master constants are held in Q1.62 and rounded down to the wanted precision.
  localparam int Q_REF = 62;
  localparam logic signed [63:0] PI_HALF_Q62 = 64'sd7244019458077122842;

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
    logic signed [63:0] mag;
    logic signed [63:0] half;
    if (sh <= 0) return v;
    half = 64'sd1 <<< (sh - 1);
    mag  = (v < 0) ? -v : v;
    mag  = (mag + half) >>> sh;
    return (v < 0) ? -mag : mag;
  endfunction

  function automatic logic signed [63:0] pi_half(input int xw);
    return round_shift(PI_HALF_Q62, Q_REF - (xw - 2));
  endfunction

  function automatic logic signed [63:0] coef(input logic mode, input logic [2:0] k, input int ifw);
    logic signed [63:0] mag;
    case ({mode, k})
      4'b0_000: mag = 64'sd4611686018427387904;
      4'b0_001: mag = 64'sd768614336404564651;
      4'b0_010: mag = 64'sd38430716820228233;
      4'b0_011: mag = 64'sd915017067148291;
      4'b0_100: mag = 64'sd12708570377060;
      4'b0_101: mag = 64'sd115532457973;
      4'b0_110: mag = 64'sd740592679;
      4'b0_111: mag = 64'sd3526632;
      4'b1_000: mag = 64'sd4611686018427387904;
      4'b1_001: mag = 64'sd2305843009213693952;
      4'b1_010: mag = 64'sd192153584101141163;
      4'b1_011: mag = 64'sd6405119470038039;
      4'b1_100: mag = 64'sd114377133393536;
      4'b1_101: mag = 64'sd1270857037706;
      4'b1_110: mag = 64'sd9627704831;
      4'b1_111: mag = 64'sd52899477;
      default:  mag = 64'sd0;
    endcase
    return round_shift(k[0] ? -mag : mag, Q_REF - ifw);
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] y, input int ifw, input int xw);
    logic signed [63:0] r;
    logic signed [63:0] lim;
    r   = round_shift(y, ifw - (xw - 2));
    lim = 64'sd1 <<< (xw - 2);
    if (r > lim) r = lim;
    else if (r < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/sine_fx_mul.sv
// rtl/sine_fx_mul.sv - combinational signed fixed-point multiply, product shifted right by IFW
module sine_fx_mul #(
  parameter int IW  = 34,
  parameter int IFW = 30
) (
  input  logic signed [IW-1:0] i_a,
  input  logic signed [IW-1:0] i_b,
  output logic signed [IW-1:0] o_p
);

  logic signed [2*IW-1:0] w_a;
  logic signed [2*IW-1:0] w_b;
  logic signed [2*IW-1:0] w_full;

  assign w_a    = (2*IW)'(i_a);
  assign w_b    = (2*IW)'(i_b);
  assign w_full = w_a * w_b;
  assign o_p    = IW'(w_full >>> IFW);

endmodule

// File: rtl/sine_cosine_horner.sv
// rtl/sine_cosine_horner.sv - sin/cos via TERMS-deep Horner polynomial on one time-shared multiplier
module sine_cosine_horner
  import sine_pkg::*;
#(
  parameter int XW    = 16,
  parameter int IFW   = 30,
  parameter int TERMS = 5
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic [XW-1:0] arg_i,
  input  logic          mode_i,
  input  logic          arg_vld_i,
  output logic          arg_rdy_o,
  output logic [XW-1:0] res_o,
  output logic          res_vld_o,
  input  logic          res_rdy_i,
  output logic          range_err_o
);

  // Two extra integer bits of headroom keep x*x (up to ~4) from wrapping.
  localparam int IW = IFW + 4;
  localparam logic [XW:0] PI_HALF_Q = (XW+1)'(pi_half(XW));

  if (TERMS < 2 || TERMS > 8) begin : g_terms_check
    $error("sine_cosine_horner: TERMS must be in 2..8");
  end
  if (IFW <= XW - 2 || IFW > 60) begin : g_ifw_check
    $error("sine_cosine_horner: IFW must exceed XW-2 and be at most 60");
  end

  state_t r_state;
  state_t w_next;

  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_x2;
  logic signed [IW-1:0] r_p;
  logic [2:0]           r_k;
  logic                 r_mode;
  logic                 r_range;
  logic [XW-1:0]        r_res;
  logic                 r_res_vld;
  logic                 r_arg_rdy;

  logic                 w_accept;
  logic                 w_hs;
  logic                 w_ld_arg;
  logic                 w_ld_sqr;
  logic                 w_ld_horn;
  logic                 w_ld_fin;
  logic signed [IW-1:0] w_mul_a;
  logic signed [IW-1:0] w_mul_b;
  logic signed [IW-1:0] w_prod;
  logic signed [IW-1:0] w_coef;
  logic signed [IW-1:0] w_x_int;
  logic signed [IW-1:0] w_y;
  logic [2:0]           w_k_sel;
  logic signed [XW:0]   w_arg_ext;
  logic [XW:0]          w_arg_abs;
  logic                 w_arg_range;
  logic [XW-1:0]        w_res;

  assign w_accept = r_arg_rdy & arg_vld_i;
  assign w_hs     = r_res_vld & res_rdy_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SQR;
      SQR:     w_next = HORN;
      HORN:    if (r_k == 3'd0) w_next = FIN;
      FIN:     w_next = DONE;
      DONE:    if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ld_arg  = 1'b0;
    w_ld_sqr  = 1'b0;
    w_ld_horn = 1'b0;
    w_ld_fin  = 1'b0;
    w_mul_a   = '0;
    w_mul_b   = '0;
    case (r_state)
      IDLE: w_ld_arg = w_accept;
      SQR: begin
        w_mul_a  = r_x;
        w_mul_b  = r_x;
        w_ld_sqr = 1'b1;
      end
      HORN: begin
        w_mul_a   = r_p;
        w_mul_b   = r_x2;
        w_ld_horn = 1'b1;
      end
      FIN: begin
        if (!r_mode) begin
          w_mul_a = r_x;
          w_mul_b = r_p;
        end
        w_ld_fin = 1'b1;
      end
      default: ;
    endcase
  end

  sine_fx_mul #(.IW(IW), .IFW(IFW)) u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  assign w_k_sel     = (r_state == SQR) ? 3'(TERMS - 1) : r_k;
  assign w_coef      = IW'(coef(r_mode, w_k_sel, IFW));
  assign w_x_int     = IW'($signed(arg_i)) <<< (IFW - (XW - 2));
  assign w_arg_ext   = (XW+1)'($signed(arg_i));
  assign w_arg_abs   = arg_i[XW-1] ? (XW+1)'(-w_arg_ext) : (XW+1)'(w_arg_ext);
  assign w_arg_range = w_arg_abs > PI_HALF_Q;
  assign w_y         = r_mode ? r_p : w_prod;
  assign w_res       = XW'(round_sat(64'(w_y), IFW, XW));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_x       <= '0;
      r_x2      <= '0;
      r_p       <= '0;
      r_k       <= '0;
      r_mode    <= 1'b0;
      r_range   <= 1'b0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_arg_rdy <= 1'b0;
    end else begin
      if (w_ld_arg) begin
        r_x     <= w_x_int;
        r_mode  <= mode_i;
        r_range <= w_arg_range;
      end
      if (w_ld_sqr) begin
        r_x2 <= w_prod;
        r_p  <= w_coef;
        r_k  <= 3'(TERMS - 2);
      end
      if (w_ld_horn) begin
        r_p <= w_prod + w_coef;
        r_k <= r_k - 3'd1;
      end
      if (w_ld_fin) r_res <= w_res;
      // The first DONE cycle is a settle cycle; valid rises on the next edge.
      r_res_vld <= (r_state == DONE) && !w_hs;
      r_arg_rdy <= (w_next == IDLE);
    end
  end

  assign arg_rdy_o   = r_arg_rdy;
  assign res_o       = r_res;
  assign res_vld_o   = r_res_vld;
  assign range_err_o = r_range;

endmodule

// File: tb/tb_sine_cosine_horner.sv
// tb/tb_sine_cosine_horner.sv - scoreboard bench for sine_cosine_horner
module tb_sine_cosine_horner;

  localparam int XW    = 16;
  localparam int IFW   = 30;
  localparam int TERMS = 5;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [XW-1:0] arg;
  logic          mode;
  logic          arg_vld;
  logic          arg_rdy;
  logic [XW-1:0] res;
  logic          res_vld;
  logic          res_rdy;
  logic          range_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int   res;
    int   tol;
    logic rng;
    logic bounds_only;
  } exp_t;

  exp_t sb[$];

  sine_cosine_horner #(.XW(XW), .IFW(IFW), .TERMS(TERMS)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .arg_i       (arg),
    .mode_i      (mode),
    .arg_vld_i   (arg_vld),
    .arg_rdy_o   (arg_rdy),
    .res_o       (res),
    .res_vld_o   (res_vld),
    .res_rdy_i   (res_rdy),
    .range_err_o (range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_tests++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic exp_t model(input logic [XW-1:0] a, input logic m);
    exp_t e;
    int   ai;
    int   r;
    real  x;
    real  y;
    ai = int'($signed(a));
    x  = $itor(ai) / 16384.0;
    y  = m ? $cos(x) : $sin(x);
    r  = int'(y * 16384.0);
    if (r > 16384)  r = 16384;
    if (r < -16384) r = -16384;
    e.res         = r;
    e.tol         = (ai == 0) ? 0 : 2;
    e.rng         = (ai > 25736 || ai < -25736);
    e.bounds_only = e.rng;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    int   sres;
    forever begin
      @(negedge clk);
      if (arst_n && res_vld && res_rdy) begin
        sres = int'($signed(res));
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0, 0);
        end else begin
          e = sb.pop_front();
          if (!e.bounds_only) check("res", sres, e.res, e.tol);
          check("res_bounds", int'(sres >= -16384 && sres <= 16384), 1, 0);
          check("range_err", int'(range_err), int'(e.rng), 0);
        end
      end
    end
  end

  int acc_cyc;

  task automatic send(input logic [XW-1:0] a, input logic m);
    int n;
    n       = 0;
    arg     = a;
    mode    = m;
    arg_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (arg_rdy) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      check("accept_timeout", 0, 1, 0);
      arg_vld = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      sb.push_back(model(a, m));
      arg_vld = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size(), 0, 0);
    @(posedge clk);
    #1;
  endtask

  logic [XW-1:0] dir_arg [10];
  logic          dir_mode[10];

  initial begin
    int n;
    int prev;
    int ai;
    arst_n  = 1'b0;
    arg     = '0;
    mode    = 1'b0;
    arg_vld = 1'b0;
    res_rdy = 1'b1;

    dir_arg[0] = 16'h2000; dir_mode[0] = 1'b0;
    dir_arg[1] = 16'hE000; dir_mode[1] = 1'b0;
    dir_arg[2] = 16'h0000; dir_mode[2] = 1'b1;
    dir_arg[3] = 16'h2000; dir_mode[3] = 1'b1;
    dir_arg[4] = 16'h9B78; dir_mode[4] = 1'b0;
    dir_arg[5] = 16'h7FFF; dir_mode[5] = 1'b0;
    dir_arg[6] = 16'h6488; dir_mode[6] = 1'b0;
    dir_arg[7] = 16'h9B78; dir_mode[7] = 1'b1;
    dir_arg[8] = 16'h8000; dir_mode[8] = 1'b1;
    dir_arg[9] = 16'h1000; dir_mode[9] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_arg_rdy", int'(arg_rdy), 0, 0);
    check("rst_res_vld", int'(res_vld), 0, 0);
    check("rst_res", int'(res), 0, 0);
    check("rst_range_err", int'(range_err), 0, 0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_arg_rdy", int'(arg_rdy), 1, 0);

    send(16'h0000, 1'b0);
    n = 0;
    while (!res_vld && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, TERMS + 2, 0);
    drain();

    for (int i = 0; i < 10; i++) begin
      prev = acc_cyc;
      send(dir_arg[i], dir_mode[i]);
      if (i > 0) check("throughput", acc_cyc - prev, TERMS + 4, 0);
    end
    for (int i = 0; i < 8; i++) begin
      ai = int'($urandom_range(0, 51472)) - 25736;
      send(XW'(ai), 1'($urandom_range(0, 1)));
    end
    drain();

    res_rdy = 1'b0;
    send(16'h2000, 1'b1);
    n = 0;
    while (!res_vld && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_vld_seen", int'(res_vld), 1, 0);
    arg     = 16'h1234;
    mode    = 1'b0;
    arg_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_vld_hold", int'(res_vld), 1, 0);
      check("bp_res_hold", int'($signed(res)), 14378, 2);
      check("bp_arg_rdy", int'(arg_rdy), 0, 0);
    end
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", int'(arg_rdy), 1, 0);
    check("bp_release_vld", int'(res_vld), 0, 0);
    send(16'h1000, 1'b0);
    prev = acc_cyc;
    send(16'hF000, 1'b1);
    check("throughput_after_bp", acc_cyc - prev, TERMS + 4, 0);
    drain();

    send(16'h2000, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_res_vld", int'(res_vld), 0, 0);
    check("midrst_arg_rdy", int'(arg_rdy), 0, 0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_release_rdy", int'(arg_rdy), 1, 0);
    repeat (TERMS + 8) @(posedge clk);
    #1;
    check("midrst_no_stale", int'(res_vld), 0, 0);
    send(16'hE000, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
